// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions for the source arbiter: opcodes, default field widths
// and a constant clog2 used when sizing the requester-index field.
package tl_ul_pkg;

  typedef enum logic [2:0] {
    A_PUT_FULL_DATA    = 3'd0,
    A_PUT_PARTIAL_DATA = 3'd1,
    A_GET              = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  localparam int TL_ADDR_W   = 64;
  localparam int TL_DATA_W   = 64;
  localparam int TL_SOURCE_W = 3;
  localparam int TL_OPCODE_W = 3;
  localparam int TL_PARAM_W  = 3;
  localparam int TL_SIZE_W   = 8;
  localparam int TL_SINK_W   = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tl_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first eligible requester found
// scanning upward from rr_ptr with wrap-around; zero latency, no state.
module tl_rr_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int IDX_WIDTH = 1
) (
  input  logic [NUM_REQ-1:0]   elig,
  input  logic [IDX_WIDTH-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IDX_WIDTH-1:0] grant_idx
);

  logic                 found;
  logic [IDX_WIDTH-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_WIDTH'((32'(rr_ptr) + k) % NUM_REQ);
      if (!found && elig[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tl_ul_source_arbiter.sv
// Shares one TL-UL A/D port among NUM_REQ requesters, one outstanding beat each; the A beat
// is registered (accept to a_valid = 1 cycle), D is routed combinationally by a_source index.
module tl_ul_source_arbiter
  import tl_ul_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int REQ_ID_WIDTH    = clog2(NUM_REQ),
  parameter int TL_ADDR_WIDTH   = TL_ADDR_W,
  parameter int TL_DATA_WIDTH   = TL_DATA_W,
  parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
  parameter int TL_SOURCE_WIDTH = TL_SOURCE_W,
  parameter int TL_OPCODE_WIDTH = TL_OPCODE_W,
  parameter int TL_PARAM_WIDTH  = TL_PARAM_W,
  parameter int TL_SIZE_WIDTH   = TL_SIZE_W,
  parameter int TL_SINK_WIDTH   = TL_SINK_W,
  localparam int LSRC           = TL_SOURCE_WIDTH - REQ_ID_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_a_valid,
  output logic [NUM_REQ-1:0]                 req_a_ready,
  input  logic [NUM_REQ*TL_OPCODE_WIDTH-1:0] req_a_opcode,
  input  logic [NUM_REQ*TL_PARAM_WIDTH-1:0]  req_a_param,
  input  logic [NUM_REQ*TL_SIZE_WIDTH-1:0]   req_a_size,
  input  logic [NUM_REQ*TL_ADDR_WIDTH-1:0]   req_a_address,
  input  logic [NUM_REQ*TL_STRB_WIDTH-1:0]   req_a_mask,
  input  logic [NUM_REQ*TL_DATA_WIDTH-1:0]   req_a_data,
  input  logic [NUM_REQ*LSRC-1:0]            req_a_source,
  output logic                               a_valid,
  output logic [TL_OPCODE_WIDTH-1:0]         a_opcode,
  output logic [TL_PARAM_WIDTH-1:0]          a_param,
  output logic [TL_ADDR_WIDTH-1:0]           a_address,
  output logic [TL_SIZE_WIDTH-1:0]           a_size,
  output logic [TL_STRB_WIDTH-1:0]           a_mask,
  output logic [TL_DATA_WIDTH-1:0]           a_data,
  output logic [TL_SOURCE_WIDTH-1:0]         a_source,
  input  logic                               a_ready,
  input  logic                               d_valid,
  output logic                               d_ready,
  input  logic [TL_OPCODE_WIDTH-1:0]         d_opcode,
  input  logic [TL_PARAM_WIDTH-1:0]          d_param,
  input  logic [TL_SIZE_WIDTH-1:0]           d_size,
  input  logic [TL_SINK_WIDTH-1:0]           d_sink,
  input  logic [TL_SOURCE_WIDTH-1:0]         d_source,
  input  logic [TL_DATA_WIDTH-1:0]           d_data,
  input  logic                               d_error,
  output logic [NUM_REQ-1:0]                 req_d_valid,
  input  logic [NUM_REQ-1:0]                 req_d_ready,
  output logic [LSRC-1:0]                    req_d_source,
  output logic [TL_OPCODE_WIDTH-1:0]         req_d_opcode,
  output logic [TL_PARAM_WIDTH-1:0]          req_d_param,
  output logic [TL_SIZE_WIDTH-1:0]           req_d_size,
  output logic [TL_SINK_WIDTH-1:0]           req_d_sink,
  output logic [TL_DATA_WIDTH-1:0]           req_d_data,
  output logic                               req_d_error,
  output logic [NUM_REQ-1:0]                 outstanding,
  output logic                               err_unmapped,
  output logic                               err_unexpected
);

  typedef struct packed {
    logic [TL_OPCODE_WIDTH-1:0] opcode;
    logic [TL_PARAM_WIDTH-1:0]  param;
    logic [TL_SIZE_WIDTH-1:0]   size;
    logic [TL_SOURCE_WIDTH-1:0] source;
    logic [TL_ADDR_WIDTH-1:0]   address;
    logic [TL_STRB_WIDTH-1:0]   mask;
    logic [TL_DATA_WIDTH-1:0]   data;
  } a_beat_t;

  a_beat_t                  req_beat [NUM_REQ];
  a_beat_t                  a_q, a_d;
  logic                     a_valid_q, a_valid_d;
  logic [NUM_REQ-1:0]       outstanding_q, outstanding_d;
  logic [REQ_ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic                     err_unmapped_q, err_unmapped_d;
  logic                     err_unexpected_q, err_unexpected_d;

  logic [NUM_REQ-1:0]       elig;
  logic [NUM_REQ-1:0]       grant;
  logic [REQ_ID_WIDTH-1:0]  grant_idx;
  logic                     load;
  logic [REQ_ID_WIDTH-1:0]  d_id;
  logic                     d_id_ok;
  logic                     d_fire;

  // Each candidate beat already carries its tagged source so the winner copies straight in.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign req_beat[g] = '{
      opcode:  req_a_opcode[g*TL_OPCODE_WIDTH +: TL_OPCODE_WIDTH],
      param:   req_a_param[g*TL_PARAM_WIDTH +: TL_PARAM_WIDTH],
      size:    req_a_size[g*TL_SIZE_WIDTH +: TL_SIZE_WIDTH],
      source:  {REQ_ID_WIDTH'(g), req_a_source[g*LSRC +: LSRC]},
      address: req_a_address[g*TL_ADDR_WIDTH +: TL_ADDR_WIDTH],
      mask:    req_a_mask[g*TL_STRB_WIDTH +: TL_STRB_WIDTH],
      data:    req_a_data[g*TL_DATA_WIDTH +: TL_DATA_WIDTH]
    };
  end

  assign elig = req_a_valid & ~outstanding_q;
  assign load = (~a_valid_q | a_ready) & (|elig);
  assign req_a_ready = load ? grant : '0;

  tl_rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (REQ_ID_WIDTH)
  ) u_rr_arbiter (
    .elig      (elig),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign d_id = d_source[TL_SOURCE_WIDTH-1 -: REQ_ID_WIDTH];

  if ((1 << REQ_ID_WIDTH) == NUM_REQ) begin : g_id_full
    assign d_id_ok = 1'b1;
  end else begin : g_id_part
    assign d_id_ok = (d_id < REQ_ID_WIDTH'(NUM_REQ));
  end

  // Unmapped responses are swallowed (d_ready=1) so a stray beat cannot wedge the D channel.
  always_comb begin
    req_d_valid = '0;
    d_ready     = 1'b1;
    if (d_id_ok) begin
      req_d_valid[d_id] = d_valid;
      d_ready           = req_d_ready[d_id];
    end
  end

  assign d_fire = d_valid & d_ready & d_id_ok;

  assign req_d_source = d_source[LSRC-1:0];
  assign req_d_opcode = d_opcode;
  assign req_d_param  = d_param;
  assign req_d_size   = d_size;
  assign req_d_sink   = d_sink;
  assign req_d_data   = d_data;
  assign req_d_error  = d_error;

  always_comb begin
    a_valid_d     = a_valid_q;
    a_d           = a_q;
    rr_ptr_d      = rr_ptr_q;
    outstanding_d = outstanding_q;
    if (load) begin
      a_valid_d                = 1'b1;
      a_d                      = req_beat[grant_idx];
      rr_ptr_d                 = (32'(grant_idx) == NUM_REQ - 1) ? '0
                                                                 : grant_idx + REQ_ID_WIDTH'(1);
      outstanding_d[grant_idx] = 1'b1;
    end else if (a_valid_q && a_ready) begin
      a_valid_d = 1'b0;
      a_d       = '0;
    end
    // A granted slot was idle, so a same-cycle clear always targets a different requester.
    if (d_fire) outstanding_d[d_id] = 1'b0;
  end

  assign err_unmapped_d   = d_valid & ~d_id_ok;
  assign err_unexpected_d = d_fire & ~outstanding_q[d_id];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q        <= 1'b0;
      a_q              <= '0;
      outstanding_q    <= '0;
      rr_ptr_q         <= '0;
      err_unmapped_q   <= 1'b0;
      err_unexpected_q <= 1'b0;
    end else begin
      a_valid_q        <= a_valid_d;
      a_q              <= a_d;
      outstanding_q    <= outstanding_d;
      rr_ptr_q         <= rr_ptr_d;
      err_unmapped_q   <= err_unmapped_d;
      err_unexpected_q <= err_unexpected_d;
    end
  end

  assign a_valid        = a_valid_q;
  assign a_opcode       = a_q.opcode;
  assign a_param        = a_q.param;
  assign a_size         = a_q.size;
  assign a_source       = a_q.source;
  assign a_address      = a_q.address;
  assign a_mask         = a_q.mask;
  assign a_data         = a_q.data;
  assign outstanding    = outstanding_q;
  assign err_unmapped   = err_unmapped_q;
  assign err_unexpected = err_unexpected_q;

endmodule

// File: tb/tb_tl_ul_source_arbiter.sv
// Randomized bench for tl_ul_source_arbiter (3 requesters, 2-bit index, 4-bit source)
// against a transaction-level reference model.
module tb_tl_ul_source_arbiter;
  import tl_ul_pkg::*;

  localparam int N  = 3;
  localparam int IDW = 2;
  localparam int SW = 4;
  localparam int LS = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int OW = 3;
  localparam int PW = 3;
  localparam int ZW = 8;
  localparam int KW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]    req_a_valid, req_a_ready;
  logic [N*OW-1:0] req_a_opcode;
  logic [N*PW-1:0] req_a_param;
  logic [N*ZW-1:0] req_a_size;
  logic [N*AW-1:0] req_a_address;
  logic [N*MW-1:0] req_a_mask;
  logic [N*DW-1:0] req_a_data;
  logic [N*LS-1:0] req_a_source;
  logic            a_valid, a_ready;
  logic [OW-1:0]   a_opcode;
  logic [PW-1:0]   a_param;
  logic [AW-1:0]   a_address;
  logic [ZW-1:0]   a_size;
  logic [MW-1:0]   a_mask;
  logic [DW-1:0]   a_data;
  logic [SW-1:0]   a_source;
  logic            d_valid, d_ready, d_error;
  logic [OW-1:0]   d_opcode;
  logic [PW-1:0]   d_param;
  logic [ZW-1:0]   d_size;
  logic [KW-1:0]   d_sink;
  logic [SW-1:0]   d_source;
  logic [DW-1:0]   d_data;
  logic [N-1:0]    req_d_valid, req_d_ready;
  logic [LS-1:0]   req_d_source;
  logic [OW-1:0]   req_d_opcode;
  logic [PW-1:0]   req_d_param;
  logic [ZW-1:0]   req_d_size;
  logic [KW-1:0]   req_d_sink;
  logic [DW-1:0]   req_d_data;
  logic            req_d_error;
  logic [N-1:0]    outstanding;
  logic            err_unmapped, err_unexpected;

  always #5 clk = ~clk;

  tl_ul_source_arbiter #(
    .NUM_REQ(N), .REQ_ID_WIDTH(IDW), .TL_ADDR_WIDTH(AW), .TL_DATA_WIDTH(DW),
    .TL_STRB_WIDTH(MW), .TL_SOURCE_WIDTH(SW), .TL_OPCODE_WIDTH(OW),
    .TL_PARAM_WIDTH(PW), .TL_SIZE_WIDTH(ZW), .TL_SINK_WIDTH(KW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a_valid(req_a_valid), .req_a_ready(req_a_ready),
    .req_a_opcode(req_a_opcode), .req_a_param(req_a_param), .req_a_size(req_a_size),
    .req_a_address(req_a_address), .req_a_mask(req_a_mask), .req_a_data(req_a_data),
    .req_a_source(req_a_source),
    .a_valid(a_valid), .a_opcode(a_opcode), .a_param(a_param), .a_address(a_address),
    .a_size(a_size), .a_mask(a_mask), .a_data(a_data), .a_source(a_source),
    .a_ready(a_ready),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_sink(d_sink), .d_source(d_source), .d_data(d_data),
    .d_error(d_error),
    .req_d_valid(req_d_valid), .req_d_ready(req_d_ready), .req_d_source(req_d_source),
    .req_d_opcode(req_d_opcode), .req_d_param(req_d_param), .req_d_size(req_d_size),
    .req_d_sink(req_d_sink), .req_d_data(req_d_data), .req_d_error(req_d_error),
    .outstanding(outstanding), .err_unmapped(err_unmapped), .err_unexpected(err_unexpected)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: the beat the slave should see, busy set, and next scan start.
  logic          m_av;
  logic [OW-1:0] m_opc;
  logic [PW-1:0] m_par;
  logic [ZW-1:0] m_siz;
  logic [SW-1:0] m_src;
  logic [AW-1:0] m_adr;
  logic [MW-1:0] m_msk;
  logic [DW-1:0] m_dat;
  logic [N-1:0]  m_out;
  int            m_ptr;
  logic          m_eum, m_eux;

  task automatic model_reset();
    m_av = 1'b0; m_opc = '0; m_par = '0; m_siz = '0; m_src = '0;
    m_adr = '0; m_msk = '0; m_dat = '0; m_out = '0; m_ptr = 0;
    m_eum = 1'b0; m_eux = 1'b0;
  endtask

  task automatic idle();
    req_a_valid = '0; req_a_opcode = '0; req_a_param = '0; req_a_size = '0;
    req_a_address = '0; req_a_mask = '0; req_a_data = '0; req_a_source = '0;
    a_ready = 1'b0; d_valid = 1'b0; d_opcode = '0; d_param = '0; d_size = '0;
    d_sink = '0; d_source = '0; d_data = '0; d_error = 1'b0; req_d_ready = '1;
  endtask

  task automatic rand_drive();
    int id;
    req_a_valid   = N'($urandom);
    req_a_opcode  = (N*OW)'($urandom);
    req_a_param   = (N*PW)'($urandom);
    req_a_size    = (N*ZW)'($urandom);
    req_a_address = {$urandom, $urandom, $urandom};
    req_a_mask    = (N*MW)'($urandom);
    req_a_data    = {$urandom, $urandom, $urandom};
    req_a_source  = (N*LS)'($urandom);
    a_ready       = ($urandom_range(0, 3) != 0);
    d_valid       = ($urandom_range(0, 1) == 1);
    id            = int'($urandom_range(0, 3));
    d_source      = SW'(id * (1 << LS) + int'($urandom_range(0, 3)));
    // A response to an idle requester must not coincide with granting that same requester.
    if (d_valid && id < N && ((m_out >> id) & N'(1)) == 0)
      req_a_valid = req_a_valid & ~N'(1 << id);
    req_d_ready = N'($urandom_range(0, 7));
    d_opcode = OW'($urandom); d_param = PW'($urandom); d_size = ZW'($urandom);
    d_sink = KW'($urandom); d_data = $urandom; d_error = 1'($urandom);
  endtask

  // Inputs are already driven; checks combinational outputs, advances the model, crosses
  // one rising edge and checks the registered outputs.
  task automatic step();
    int win, id;
    logic ld, fire, n_eum, n_eux, e_dr;
    logic [N-1:0] e_rdy, e_rdv;
    #1;
    win = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (win < 0 && ((req_a_valid >> c) & N'(1)) != 0 && ((m_out >> c) & N'(1)) == 0)
        win = c;
    end
    ld = (!m_av || a_ready) && win >= 0;
    e_rdy = ld ? N'(1 << win) : '0;
    id = int'(d_source) >> LS;
    e_rdv = '0;
    e_dr = 1'b1;
    if (id < N) begin
      e_rdv = d_valid ? N'(1 << id) : '0;
      e_dr = ((req_d_ready >> id) & N'(1)) != 0;
    end
    check_eq("req_a_ready", 64'(req_a_ready), 64'(e_rdy));
    check_eq("d_ready", 64'(d_ready), 64'(e_dr));
    check_eq("req_d_valid", 64'(req_d_valid), 64'(e_rdv));
    check_eq("req_d_source", 64'(req_d_source), 64'(int'(d_source) % (1 << LS)));
    check_eq("req_d_data", 64'(req_d_data), 64'(d_data));
    fire = d_valid && e_dr && id < N;
    n_eum = d_valid && id >= N;
    n_eux = fire && ((m_out >> id) & N'(1)) == 0;
    if (ld) begin
      m_av  = 1'b1;
      m_opc = OW'(req_a_opcode >> (win * OW));
      m_par = PW'(req_a_param >> (win * PW));
      m_siz = ZW'(req_a_size >> (win * ZW));
      m_adr = AW'(req_a_address >> (win * AW));
      m_msk = MW'(req_a_mask >> (win * MW));
      m_dat = DW'(req_a_data >> (win * DW));
      m_src = SW'(win * (1 << LS) + int'(LS'(req_a_source >> (win * LS))));
      m_out = m_out | N'(1 << win);
      m_ptr = (win + 1) % N;
    end else if (m_av && a_ready) begin
      m_av = 1'b0; m_opc = '0; m_par = '0; m_siz = '0;
      m_adr = '0; m_msk = '0; m_dat = '0; m_src = '0;
    end
    if (fire) m_out = m_out & ~N'(1 << id);
    m_eum = n_eum;
    m_eux = n_eux;
    @(posedge clk);
    #1;
    check_eq("a_valid", 64'(a_valid), 64'(m_av));
    check_eq("a_source", 64'(a_source), 64'(m_src));
    check_eq("a_opcode", 64'(a_opcode), 64'(m_opc));
    check_eq("a_param", 64'(a_param), 64'(m_par));
    check_eq("a_size", 64'(a_size), 64'(m_siz));
    check_eq("a_address", 64'(a_address), 64'(m_adr));
    check_eq("a_mask", 64'(a_mask), 64'(m_msk));
    check_eq("a_data", 64'(a_data), 64'(m_dat));
    check_eq("outstanding", 64'(outstanding), 64'(m_out));
    check_eq("err_unmapped", 64'(err_unmapped), 64'(m_eum));
    check_eq("err_unexpected", 64'(err_unexpected), 64'(m_eux));
  endtask

  initial begin
    model_reset();
    idle();
    #1;
    check_eq("rst_a_valid", 64'(a_valid), 64'(0));
    check_eq("rst_a_source", 64'(a_source), 64'(0));
    check_eq("rst_a_address", 64'(a_address), 64'(0));
    check_eq("rst_outstanding", 64'(outstanding), 64'(0));
    check_eq("rst_err_unmapped", 64'(err_unmapped), 64'(0));
    check_eq("rst_err_unexpected", 64'(err_unexpected), 64'(0));
    #11 rst_n = 1'b1;

    // Single Get from requester 0, local source 2.
    req_a_valid = 3'b001;
    req_a_opcode = (N*OW)'(int'(A_GET));
    req_a_address = (N*AW)'(32'h100);
    req_a_source = (N*LS)'(2);
    a_ready = 1'b1;
    step();
    check_eq("get_a_source", 64'(a_source), 64'(4'b0010));
    check_eq("get_outstanding", 64'(outstanding), 64'(3'b001));
    idle(); a_ready = 1'b1;
    step();
    d_valid = 1'b1; d_source = 4'b0010;
    #1 check_eq("get_req_d_valid", 64'(req_d_valid), 64'(3'b001));
    step();
    check_eq("get_cleared", 64'(outstanding), 64'(0));

    // A slave stall holds the beat while other requesters wait.
    idle();
    req_a_valid = 3'b010; req_a_address = {32'h0, 32'hCAFE0000, 32'h0};
    step();
    for (int i = 0; i < 5; i++) begin
      rand_drive();
      req_a_valid = 3'b101; a_ready = 1'b0; d_valid = 1'b0;
      step();
    end
    check_eq("stall_hold_addr", 64'(a_address), 64'(32'hCAFE0000));
    rand_drive(); req_a_valid = 3'b101; a_ready = 1'b1; d_valid = 1'b0;
    step();

    // Unmapped index 3 is swallowed and flagged.
    idle(); d_valid = 1'b1; d_source = 4'b1101; req_d_ready = '0;
    #1 check_eq("unmapped_d_ready", 64'(d_ready), 64'(1));
    step();
    check_eq("unmapped_pulse", 64'(err_unmapped), 64'(1));

    for (int i = 0; i < 800; i++) begin
      rand_drive();
      step();
    end

    // Get a beat in flight, then reset in the middle of the cycle.
    for (int t = 0; t < 10 && !m_av; t++) begin
      idle(); req_a_valid = '1; a_ready = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
        if (((m_out >> k) & N'(1)) != 0) begin
          d_valid = 1'b1; d_source = SW'(k * (1 << LS));
        end
      end
      step();
    end
    check_eq("pre_reset_a_valid", 64'(a_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_a_valid", 64'(a_valid), 64'(0));
    check_eq("async_rst_outstanding", 64'(outstanding), 64'(0));
    check_eq("async_rst_a_source", 64'(a_source), 64'(0));
    model_reset();
    #2 rst_n = 1'b1;
    idle(); d_valid = 1'b1; d_source = 4'b0001;
    step();
    check_eq("unexpected_pulse", 64'(err_unexpected), 64'(1));
    idle();
    step();
    check_eq("unexpected_drop", 64'(err_unexpected), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
